// File: rtl/dmem_resp_pkg.sv
// Shared types for the dmem_resp data-memory responder: request/response
// port structs, FSM state encoding, decoded-request and response-register
// structs, and the address window helper.
package dmem_resp_wires;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_READ  = 2'd0,
        K_WRITE = 2'd1,
        K_FENCE = 2'd2
    } kind_t;

    // Request as decoded at the accept edge and latched until its response.
    typedef struct packed {
        kind_t       kind;
        logic [31:0] widx;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        err;
    } req_t;

    // Registered response flags; rd_en selects RAM read data onto mem_rdata.
    typedef struct packed {
        logic ready;
        logic err;
        logic rd_en;
    } resp_t;

    localparam resp_t init_resp = '{ready: 1'b0, err: 1'b0, rd_en: 1'b0};

    localparam int CNT_W = 5;

    // True when base <= addr < base + span (33-bit math, no wraparound).
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [32:0] span);
        return ({1'b0, addr} >= {1'b0, base}) &&
               ({1'b0, addr} <  ({1'b0, base} + span));
    endfunction

endpackage

// File: rtl/dmem_resp_ram.sv
// Word-addressed backing RAM: byte-strobe write port, registered read
// address, read data driven combinationally from the registered address.
module dmem_resp_ram #(
    parameter int DEPTH = 12
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [3:0]       wstrb_i,
    input  logic [31:0]      wdata_i,
    input  logic             re_i,
    input  logic [DEPTH-1:0] addr_i,
    output logic [31:0]      rdata_o
);

    logic [31:0]      mem_q [2**DEPTH];
    logic [DEPTH-1:0] raddr_q;

    // Byte-lane write of the strobed bytes.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Capture the read address when a read is accepted; it holds until the next read.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            raddr_q <= addr_i;
        end
    end

    assign rdata_o = mem_q[raddr_q];

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder. Accepts one request at a time, answers
// after WAIT_CYCLES (plus a random 0..3 when DMEM_RESP_RANDOM_WAIT_EN is
// defined), and accepts the next request on the edge that ends RESP.
module dmem_resp
    import dmem_resp_wires::*;
#(
    parameter int          DEPTH       = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    output logic        mem_err
);

    localparam logic [32:0] SPAN = 33'd4 << DEPTH;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lat;
    req_t             req_q, req_d, req_n;
    resp_t            resp_q, resp_d;
    logic             accept;
    logic [1:0]       extra;
    logic [31:0]      off;
    logic [31:0]      ram_rdata;

`ifdef DMEM_RESP_RANDOM_WAIT_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Free-running Fibonacci LFSR (taps 16,14,13,11) for extra wait states.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign extra = lfsr_q[1:0];
`else
    logic unused_seed;

    assign extra       = 2'b00;
    assign unused_seed = ^LFSR_SEED;
`endif

    assign off = dmem_in.mem_addr - BASE_ADDR;

    // Decode the incoming request: kind, word index and range check.
    always_comb begin
        req_d       = '0;
        req_d.widx  = {2'b00, off[31:2]};
        req_d.wdata = dmem_in.mem_wdata;
        req_d.wstrb = dmem_in.mem_wstrb;
        req_d.err   = !dmem_in.mem_fence && !in_window(dmem_in.mem_addr, BASE_ADDR, SPAN);
        if (dmem_in.mem_fence) begin
            req_d.kind = K_FENCE;
        end else if (|dmem_in.mem_wstrb) begin
            req_d.kind = K_WRITE;
        end else begin
            req_d.kind = K_READ;
        end
    end

    // Next state, wait counter and the response flags for the coming cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_n   = req_q;
        accept  = 1'b0;
        resp_d  = init_resp;
        lat     = CNT_W'(WAIT_CYCLES) + {{(CNT_W-2){1'b0}}, extra};
        case (state_q)
            IDLE, RESP: begin
                if (dmem_in.mem_valid) begin
                    accept = 1'b1;
                    req_n  = req_d;
                    if (lat == '0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = lat - 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == RESP) begin
            resp_d.ready = 1'b1;
            resp_d.err   = req_n.err;
            resp_d.rd_en = (req_n.kind == K_READ) && !req_n.err;
        end
    end

    // Control state: FSM, counter and registered response flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            resp_q  <= init_resp;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
        end
    end

    // Latch the accepted request until its response is issued.
    always_ff @(posedge clk) begin
        req_q <= req_n;
    end

    dmem_resp_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (accept && (req_d.kind == K_WRITE) && !req_d.err),
        .wstrb_i (req_d.wstrb),
        .wdata_i (req_d.wdata),
        .re_i    (accept && (req_d.kind == K_READ) && !req_d.err),
        .addr_i  (req_d.widx[DEPTH-1:0]),
        .rdata_o (ram_rdata)
    );

    assign dmem_out = '{mem_ready: resp_q.ready,
                        mem_rdata: resp_q.rd_en ? ram_rdata : 32'h0};
    assign mem_err  = resp_q.err;

    logic unused_bits;
    assign unused_bits = ^{dmem_in.mem_instr, off[1:0], req_d.widx[31:DEPTH],
                           req_q.widx, req_q.wdata, req_q.wstrb};

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Memory-side responder for the `mem_in_type` / `mem_out_type` request interface: the target that a data TIM or cache talks to through its `dmem_in` / `dmem_out` ports. It holds a word-addressed backing RAM and completes one request at a time after a programmable wait-state latency. It acknowledges fences, and supports back-to-back requests so line refills and writebacks run at full rate. It sits below the data TIM in simulation and FPGA builds as the data memory model.

## Interface

Parameters:
- `DEPTH`, 12: log2 of RAM words; capacity is 4·2^DEPTH bytes.
- `BASE_ADDR`, 32'h0: byte address of word 0.
- `WAIT_CYCLES`, 0: fixed wait states per request (0..15).
- `LFSR_SEED`, 16'hACE1: nonzero seed for the random-wait LFSR.

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `dmem_in` input `mem_in_type`: request (`mem_valid`, `mem_fence`, `mem_instr`, `mem_addr`, `mem_wdata`, `mem_wstrb`).
- `dmem_out` output `mem_out_type`: response (`mem_ready`, `mem_rdata`).
- `mem_err` output 1: out-of-range flag, asserted only together with `mem_ready`.

## Operation

States:
- **IDLE**: no request outstanding.
- **WAIT**: counting wait states.
- **RESP**: the cycle in which `mem_ready` is 1.

Request acceptance:
- A request is accepted on a rising edge when `mem_valid`=1 and the state is IDLE or RESP.
- In WAIT, `mem_valid` is ignored. The initiator holds the request until it sees ready.
- The accepted fields are latched.
- Latency L = `WAIT_CYCLES` plus the random extra (see Configuration).
- If L=0, the next state is RESP. Otherwise the next state is WAIT, with the counter loaded to L-1.

WAIT:
- The counter decrements each cycle.
- At 0, the next state is RESP.

RESP:
- `mem_ready`=1 for exactly one cycle.
- If a new request is accepted on the same edge, the FSM goes to RESP or WAIT as above. Otherwise it goes to IDLE.

Request kinds:
- **Write** (`mem_wstrb`≠0, in range): bytes with a set strobe are written at word `(addr-BASE_ADDR)>>2` on the accept edge. The response has `mem_rdata`=0.
- **Read** (`mem_wstrb`=0, in range): `mem_rdata` is the word content in the RESP cycle. It includes every write accepted earlier.
- **Fence** (`mem_fence`=1): no RAM access. Ready after L cycles, `mem_rdata`=0.
- **Out of range** (addr < BASE_ADDR or addr ≥ BASE_ADDR+4·2^DEPTH): no write. Ready with `mem_rdata`=0 and `mem_err`=1.

Other rules:
- `mem_instr` is ignored.
- `mem_addr[1:0]` is ignored.
- Outside RESP, `mem_ready`, `mem_rdata` and `mem_err` are 0.

## Timing

- Request accepted at edge N: `mem_ready` is high in cycle N+1+L.
- With L=0 and `mem_valid` held continuously high, `mem_ready` is high every cycle (throughput 1/cycle).
- All outputs are registered. There is no combinational path from `dmem_in` to `dmem_out`.
- Reset (asynchronous, any state, including mid-WAIT):
  - FSM goes to IDLE; `mem_ready`, `mem_rdata`, `mem_err` and the counter go to 0.
  - The LFSR is loaded with `LFSR_SEED`.
  - The request in flight is dropped.
- RAM contents are not reset; they are zero at power-up.
- Simultaneous RESP and new request: the response completes and the new request is accepted on the same edge.

## Configuration

- Macro `DMEM_RESP_RANDOM_WAIT_EN`.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle out of reset.
  - Each accepted request gets an extra latency of `lfsr[1:0]` (0..3), sampled at the accept edge.
  - L = `WAIT_CYCLES` + `lfsr[1:0]`.
- Undefined: no LFSR logic; L = `WAIT_CYCLES` exactly.

## Structure

- Package `dmem_resp_wires` holds:
  - state encoding constants `IDLE`/`WAIT`/`RESP`;
  - the latched-request struct (kind, word index, wdata, wstrb, err);
  - the response register struct and its `init_` constant.
- Sub-module `dmem_resp_ram`:
  - `2**DEPTH` × 32-bit array;
  - byte-strobe write port;
  - read address registered, read data driven combinationally from the registered address.
- Top module `dmem_resp`: FSM, wait counter, LFSR, range check and output registers.

## Test plan

- **Write then read:** `WAIT_CYCLES`=0, macro off. Write 0xDEADBEEF, strobe F, at BASE+0x100; then read BASE+0x100. Ready one cycle after each accept; read returns 0xDEADBEEF.
- **Byte strobe:** write 0x000000AA with strobe 0001 at the same address, then read. Read returns 0xDEADBEAA.
- **Wait states:** `WAIT_CYCLES`=3. Read accepted at edge 10 with `mem_valid` held high. `mem_ready` is high only in cycle 14, and the held valid in cycles 11–13 causes no extra accepts.
- **Back-to-back refill:** `WAIT_CYCLES`=0. Reads of BASE+0x200..0x20C, with the address advanced on each ready. Ready in four consecutive cycles, with data in address order.
- **Fence and out of range:**
  - Fence: ready after L cycles, `mem_rdata`=0, RAM unchanged.
  - Write to BASE+4·2^DEPTH: ready with `mem_err`=1, and a subsequent read of word 0 is unchanged.
- **Reset mid-request:** `rst` driven low during WAIT. Outputs go to 0 immediately; no ready follows; a fresh read after release completes normally.
